// File: rtl/half_subtractor_pkg.sv
// half_subtractor_pkg: shared constants and types for the half subtractor.
// Holds the default borrow-counter width and the {diff, borrow} result type
// used by the cell, the registered path and the counter.
package half_subtractor_pkg;

  // Default width of the borrow-event counter.
  localparam int unsigned CNT_W_DEFAULT = 32'd8;

  // One half-subtractor result: difference and borrow-out bits.
  typedef struct packed {
    logic diff;
    logic borrow;
  } hs_res_t;

endpackage : half_subtractor_pkg

// File: rtl/half_sub_cell.sv
// half_sub_cell: purely combinational single-bit subtractor a - b.
// diff = a XOR b, borrow = (NOT a) AND b.
module half_sub_cell
  import half_subtractor_pkg::*;
(
  input  logic    a_i,
  input  logic    b_i,
  output hs_res_t res_o
);

  assign res_o.diff   = a_i ^ b_i;
  assign res_o.borrow = (~a_i) & b_i;

endmodule : half_sub_cell

// File: rtl/half_subtractor.sv
// half_subtractor: combinational half subtractor with a registered,
// valid-qualified copy of the result and an optional saturating count of
// accepted borrow events.
// Build option: define HALF_SUBTRACTOR_STATS_EN to implement the borrow
// counter; otherwise borrow_cnt is tied to zero, cnt_clr is ignored and no
// counter flops exist. The port list is the same in both builds.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             D,
  output logic             B,
  input  logic             in_valid,
  output logic             D_q,
  output logic             B_q,
  output logic             out_valid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] borrow_cnt
);

  // Single shared subtractor cell feeds every consumer of the result.
  hs_res_t res_s;

  half_sub_cell u_cell (
    .a_i   (a),
    .b_i   (b),
    .res_o (res_s)
  );

  // Combinational outputs stay live through reset.
  assign D = res_s.diff;
  assign B = res_s.borrow;

  hs_res_t res_q;
  hs_res_t res_d;
  logic    valid_q;
  logic    valid_d;

  // Capture the result only on accepted inputs so a/b are ignored otherwise.
  always_comb begin
    res_d   = res_q;
    valid_d = in_valid;
    if (in_valid) begin
      res_d = res_s;
    end else begin
      res_d = res_q;
    end
  end

  // Result and valid registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '{diff: 1'b0, borrow: 1'b0};
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign D_q       = res_q.diff;
  assign B_q       = res_q.borrow;
  assign out_valid = valid_q;

`ifdef HALF_SUBTRACTOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; increment saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (in_valid && res_s.borrow && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Borrow-event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`else
  // Counter not built: clear input intentionally has no effect.
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = cnt_clr;
  assign borrow_cnt       = {CNT_W{1'b0}};
`endif

endmodule : half_subtractor

// File: tb/tb_half_subtractor.sv
// tb_half_subtractor: self-checking bench for half_subtractor.
// Two instances share stimulus: default width and CNT_W=2 for saturation.
// Expected counter behaviour follows HALF_SUBTRACTOR_STATS_EN.
module tb_half_subtractor;

`ifdef HALF_SUBTRACTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       in_valid;
  logic       cnt_clr;
  logic       d_s, bo_s, dq_s, bq_s, ov_s;
  logic [7:0] cnt8_s;
  logic       d2_s, bo2_s, dq2_s, bq2_s, ov2_s;
  logic [1:0] cnt2_s;

  int n_tests;
  int n_fail;

  // reference model state
  int m_dq, m_bq, m_ov, m_cnt8, m_cnt2;

  half_subtractor #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .D(d_s), .B(bo_s),
    .in_valid(in_valid), .D_q(dq_s), .B_q(bq_s), .out_valid(ov_s),
    .cnt_clr(cnt_clr), .borrow_cnt(cnt8_s)
  );

  half_subtractor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .D(d2_s), .B(bo2_s),
    .in_valid(in_valid), .D_q(dq2_s), .B_q(bq2_s), .out_valid(ov2_s),
    .cnt_clr(cnt_clr), .borrow_cnt(cnt2_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic d;
    logic bo;
  } tt_vec_t;

  typedef struct {
    logic a;
    logic b;
  } in_vec_t;

  // Arithmetic view of a - b on single bits.
  function automatic int ref_diff(input logic ai, input logic bi);
    return ((int'(ai) - int'(bi)) % 2 + 2) % 2;
  endfunction

  function automatic int ref_borrow(input logic ai, input logic bi);
    return (int'(ai) < int'(bi)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_comb();
    check("D", int'(d_s), ref_diff(a, b));
    check("B", int'(bo_s), ref_borrow(a, b));
  endtask

  task automatic check_all();
    check_comb();
    check("D_q", int'(dq_s), m_dq);
    check("B_q", int'(bq_s), m_bq);
    check("out_valid", int'(ov_s), m_ov);
    check("borrow_cnt8", int'(cnt8_s), m_cnt8);
    check("borrow_cnt2", int'(cnt2_s), m_cnt2);
    check("out_valid2", int'(ov2_s), m_ov);
  endtask

  task automatic model_reset();
    m_dq = 0; m_bq = 0; m_ov = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_ov = int'(in_valid);
      if (in_valid) begin
        m_dq = ref_diff(a, b);
        m_bq = ref_borrow(a, b);
      end
      if (STATS) begin
        if (cnt_clr) begin
          m_cnt8 = 0;
          m_cnt2 = 0;
        end else if (in_valid && ref_borrow(a, b) == 1) begin
          m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
          m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic av, input logic bv, input logic v, input logic c);
    a = av; b = bv; in_valid = v; cnt_clr = c;
  endtask

  tt_vec_t tt[4];
  in_vec_t seq[4];
  int exp_dq_seq[4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    tt[0] = '{a: 1'b0, b: 1'b0, d: 1'b0, bo: 1'b0};
    tt[1] = '{a: 1'b0, b: 1'b1, d: 1'b1, bo: 1'b1};
    tt[2] = '{a: 1'b1, b: 1'b0, d: 1'b1, bo: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, d: 1'b0, bo: 1'b0};
    seq[0] = '{a: 1'b0, b: 1'b1};
    seq[1] = '{a: 1'b0, b: 1'b0};
    seq[2] = '{a: 1'b0, b: 1'b1};
    seq[3] = '{a: 1'b1, b: 1'b1};
    exp_dq_seq[0] = 1; exp_dq_seq[1] = 0; exp_dq_seq[2] = 1; exp_dq_seq[3] = 0;

    // Reset state
    #3;
    check_all();

    // Truth table held in reset: combinational path only
    for (int i = 0; i < 4; i++) begin
      a = tt[i].a;
      b = tt[i].b;
      #100;
      check("tt_D", int'(d_s), int'(tt[i].d));
      check("tt_B", int'(bo_s), int'(tt[i].bo));
      check("tt_Dq_rst", int'(dq_s), 0);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Four back-to-back accepted inputs
    for (int i = 0; i < 4; i++) begin
      drive(seq[i].a, seq[i].b, 1'b1, 1'b0);
      tick();
      check("seq_Dq", int'(dq_s), exp_dq_seq[i]);
      check("seq_Bq", int'(bq_s), exp_dq_seq[i]);
      check("seq_ov", int'(ov_s), 1);
    end
    check("seq_cnt", int'(cnt8_s), STATS ? 2 : 0);

    // Idle edge: valid drops, data holds, a/b ignored
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("idle_ov", int'(ov_s), 0);
    check("idle_Dq_hold", int'(dq_s), 0);

    // Clear beats a simultaneous borrow increment
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    check("clr_prio", int'(cnt8_s), 0);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    check("sat_cnt2", int'(cnt2_s), STATS ? 3 : 0);
    check("sat_cnt8", int'(cnt8_s), STATS ? 5 : 0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end

    // Reset mid-cycle with a valid result present
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_ov", int'(ov_s), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    a = 1'b1; b = 1'b0;
    #1;
    check_comb();
    a = 1'b0; b = 1'b1;
    #1;
    check_comb();
    tick();

    // First accepted input after reset release
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("post_rst_Dq", int'(dq_s), 1);
    check("post_rst_ov", int'(ov_s), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_half_subtractor
